// File: rtl/jtkcpu_busctl_if.sv
// Bus bundle between the CPU control unit, the bus controller and the external 8-bit memory bus.
interface jtkcpu_busctl_if;
  logic        req;
  logic        wrq;
  logic        mem16;
  logic        memhi;
  logic [15:0] addr;
  logic [15:0] dout;
  logic        mem_busy;
  logic [15:0] data;
  logic        done;
  logic        buserr;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_cs;
  logic        bus_we;
  logic [7:0]  bus_din;
  logic        bus_ok;

  modport slave (
    input  req, wrq, mem16, memhi, addr, dout, bus_din, bus_ok,
    output mem_busy, data, done, buserr, bus_addr, bus_dout, bus_cs, bus_we
  );

  modport master (
    output req, wrq, mem16, memhi, addr, dout, bus_din, bus_ok,
    input  mem_busy, data, done, buserr, bus_addr, bus_dout, bus_cs, bus_we
  );
endinterface

// File: rtl/jtkcpu_busctl.sv
// Splits CPU data accesses into big-endian 8-bit bus cycles, with wait states and a
// wait-state watchdog that aborts a hung byte and pulses buserr.
module jtkcpu_busctl #(
  parameter int unsigned TOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  jtkcpu_busctl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, HI, LO} state_t;

  state_t      state, state_nxt;
  logic        l_wrq, l_mem16;
  logic [15:0] l_addr;
  logic [7:0]  l_dout_lo;
  logic [7:0]  wcnt;
  logic [15:0] data;
  logic        done, buserr, bus_cs, bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        accept, byte_ok, timeout;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    byte_ok   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: if (bus.req && cen) begin
        accept    = 1'b1;
        state_nxt = HI;
      end
      HI, LO: if (cen) begin
        if (bus.bus_ok) begin
          byte_ok   = 1'b1;
          state_nxt = (state == HI && l_mem16) ? LO : IDLE;
        end else if (TOUT != 0 && wcnt == 8'(TOUT - 1)) begin
          // This wait cen would bring the counter to TOUT: give up on the byte.
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_wrq     <= 1'b0;
      l_mem16   <= 1'b0;
      l_addr    <= '0;
      l_dout_lo <= '0;
      wcnt      <= '0;
      data      <= '0;
      done      <= 1'b0;
      buserr    <= 1'b0;
      bus_cs    <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_dout  <= '0;
    end else begin
      // Pulses last exactly one clk, whatever cen does.
      done   <= 1'b0;
      buserr <= 1'b0;
      if (accept) begin
        l_wrq     <= bus.wrq;
        l_mem16   <= bus.mem16;
        l_addr    <= bus.addr;
        l_dout_lo <= bus.dout[7:0];
        wcnt      <= '0;
        bus_addr  <= bus.addr;
        bus_cs    <= 1'b1;
        bus_we    <= bus.wrq;
        bus_dout  <= (bus.mem16 || bus.memhi) ? bus.dout[15:8] : bus.dout[7:0];
      end else if (byte_ok) begin
        wcnt <= '0;
        if (state == HI && l_mem16) begin
          if (!l_wrq) data[15:8] <= bus.bus_din;
          else        bus_dout   <= l_dout_lo;
          bus_addr <= l_addr + 16'd1;
        end else begin
          if (!l_wrq) begin
            if (state == HI) data      <= {8'h00, bus.bus_din};
            else             data[7:0] <= bus.bus_din;
          end
          done   <= 1'b1;
          bus_cs <= 1'b0;
          bus_we <= 1'b0;
        end
      end else if (timeout) begin
        wcnt   <= '0;
        buserr <= 1'b1;
        bus_cs <= 1'b0;
        bus_we <= 1'b0;
        if (!l_wrq) data <= 16'hFFFF;
      end else if (cen && state != IDLE) begin
        wcnt <= wcnt + 8'd1;
      end
    end
  end

  assign bus.mem_busy = (state != IDLE) || bus.req;
  assign bus.data     = data;
  assign bus.done     = done;
  assign bus.buserr   = buserr;
  assign bus.bus_addr = bus_addr;
  assign bus.bus_dout = bus_dout;
  assign bus.bus_cs   = bus_cs;
  assign bus.bus_we   = bus_we;

endmodule
